// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter and its sipo partner.
package piso_pkg;

    // Word width used by default on both ends of the serial link.
    localparam int PISO_WIDTH = 4;

    // Encoding values: idle = 0, shift = 1, gap = 2.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/piso_if.sv
// Word handshake plus serial output bundle of the transmitter.
interface piso_if #(
    parameter int WIDTH = piso_pkg::PISO_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             so;
    logic             so_valid;
    logic             so_last;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, so, so_valid, so_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, so, so_valid, so_last, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, LSB first, with a one-word holding buffer
// and an optional idle gap after every frame.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | nothing on the line; load as soon as the holding buffer fills
//   ST_SHIFT | a frame bit is on so every cycle; cnt is the bit index
//   ST_GAP   | GAP idle cycles after a frame; gcnt counts them
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH,
    parameter int GAP   = 0
) (
    input logic     clk,
    input logic     rst,
    piso_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             so_valid_r;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gcnt;
    logic             accept;
    logic             load;

    // in_ready comes straight from hold_full, so accept never loops back through in_valid.
    assign accept = bus.in_valid & ~hold_full;

    // Decide whether the holding buffer moves into the shift register on this edge.
    always_comb begin
        load = 1'b0;
        if (hold_full) begin
            case (state)
                ST_IDLE:  load = 1'b1;
                ST_SHIFT: load = (GAP == 0) && (cnt == CNT_LAST);
                ST_GAP:   load = (gcnt == GAP_LAST);
                default:  load = 1'b0;
            endcase
        end
    end

    // Holding buffer: filled by an accept, emptied by a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept)
                hold <= bus.in_data;
            hold_full <= accept | (hold_full & ~load);
        end
    end

    // Frame sequencer: shift out bits, insert the gap, chain the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            so_valid_r <= 1'b0;
        end else if (load) begin
            sreg       <= hold;
            cnt        <= '0;
            so_valid_r <= 1'b1;
            state      <= ST_SHIFT;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        so_valid_r <= 1'b0;
                        if (GAP > 0) begin
                            gcnt  <= '0;
                            state <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        sreg <= sreg >> 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (gcnt == GAP_LAST)
                        state <= ST_IDLE;
                    else
                        gcnt <= gcnt + GW'(1);
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.so       = so_valid_r & sreg[0];
    assign bus.so_valid = so_valid_r;
    assign bus.so_last  = so_valid_r & (cnt == CNT_LAST);
    assign bus.busy     = (state != ST_IDLE) | hold_full;
    assign bus.in_ready = ~hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two instances (GAP=0 and GAP=2) checked every cycle against
// a timeline model of accepted words, plus directed scenarios with literal results.
module tb_piso_tx;
    import piso_pkg::*;

    localparam int W  = PISO_WIDTH;
    localparam int G0 = 0;
    localparam int G1 = 2;
    localparam int NMAX = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv [2];
    logic [W-1:0] id [2];

    piso_if #(.WIDTH(W)) bus0 ();
    piso_if #(.WIDTH(W)) bus1 ();

    assign bus0.in_valid = iv[0];
    assign bus0.in_data  = id[0];
    assign bus1.in_valid = iv[1];
    assign bus1.in_data  = id[1];

    piso_tx #(.WIDTH(W), .GAP(G0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    piso_tx #(.WIDTH(W), .GAP(G1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic o_so [2], o_v [2], o_last [2], o_busy [2], o_rdy [2];
    assign o_so[0]   = bus0.so;       assign o_so[1]   = bus1.so;
    assign o_v[0]    = bus0.so_valid; assign o_v[1]    = bus1.so_valid;
    assign o_last[0] = bus0.so_last;  assign o_last[1] = bus1.so_last;
    assign o_busy[0] = bus0.busy;     assign o_busy[1] = bus1.busy;
    assign o_rdy[0]  = bus0.in_ready; assign o_rdy[1]  = bus1.in_ready;

    // Timeline model: each accepted word has an accept edge fa and a start edge fs.
    // Bit j of a frame is on the line after edge fs+j; the line is then busy for
    // GAP more edges; a new frame starts no earlier than the edge after its accept.
    int           ecnt = 0;
    int           fa [2][0:NMAX-1];
    int           fs [2][0:NMAX-1];
    logic [W-1:0] fw [2][0:NMAX-1];
    int           nf [2] = '{0, 0};
    int           acc_cnt [2] = '{0, 0};

    int ntests = 0;
    int nfail  = 0;

    // Receive side, as a chained sipo would see it.
    logic [W-1:0] po [2];
    logic [W-1:0] rxw [2][0:NMAX-1];
    int           nrx [2] = '{0, 0};
    bit           after_last [2];
    int           zc [2];
    int           gapv [2] = '{-1, -1};

    function automatic int gv(input int k);
        return (k == 0) ? G0 : G1;
    endfunction

    function automatic bit m_ready(input int k, input int e);
        for (int i = nf[k] - 1; i >= 0 && i >= nf[k] - 4; i--)
            if (fa[k][i] <= e && e < fs[k][i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_busy(input int k, input int e);
        for (int i = nf[k] - 1; i >= 0 && i >= nf[k] - 4; i--)
            if (fa[k][i] <= e && e <= fs[k][i] + W + gv(k) - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_out(input int k, input int e, output bit v, output bit b, output bit l);
        v = 1'b0; b = 1'b0; l = 1'b0;
        for (int i = nf[k] - 1; i >= 0 && i >= nf[k] - 4; i--) begin
            if (fs[k][i] <= e && e <= fs[k][i] + W - 1) begin
                v = 1'b1;
                b = fw[k][i][e - fs[k][i]];
                l = (e == fs[k][i] + W - 1);
            end
        end
    endfunction

    // Model update at each edge, using the buffer state left by the previous edge.
    bit mr [2];
    int st;
    always @(posedge clk) begin
        if (rst) begin
            nf[0] = 0;
            nf[1] = 0;
            ecnt  = ecnt + 1;
        end else begin
            for (int k = 0; k < 2; k++) mr[k] = m_ready(k, ecnt);
            ecnt = ecnt + 1;
            for (int k = 0; k < 2; k++) begin
                if (iv[k] && mr[k] && nf[k] < NMAX) begin
                    st = ecnt + 1;
                    if (nf[k] > 0 && fs[k][nf[k]-1] + W + gv(k) > st)
                        st = fs[k][nf[k]-1] + W + gv(k);
                    fa[k][nf[k]] = ecnt;
                    fs[k][nf[k]] = st;
                    fw[k][nf[k]] = id[k];
                    nf[k]      = nf[k] + 1;
                    acc_cnt[k] = acc_cnt[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s[%0d] edge %0d: got %0h, expected %0h", nm, k, ecnt, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a word on instance k and keep it offered until the model accepts it.
    task automatic send(input int k, input logic [W-1:0] w);
        int n0;
        bit got;
        n0    = acc_cnt[k];
        got   = 1'b0;
        iv[k] = 1'b1;
        id[k] = w;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            #1;
            got = (acc_cnt[k] != n0);
        end
        if (!got) begin
            ntests++;
            nfail++;
            $display("FAIL send_timeout[%0d]: word %0h not accepted within 40 cycles", k, w);
        end
    endtask

    bit ev, eb, el;
    int b0 [2];
    int a0 [2];
    int m0 [2];
    int seen [2];

    initial begin
        rst   = 1'b1;
        iv[0] = 1'b0; iv[1] = 1'b0;
        id[0] = '0;   id[1] = '0;

        fork
            // Per-cycle compare of both instances against the model.
            forever begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    if (rst) begin
                        chk("rst_so", k, int'(o_so[k]), 0);
                        chk("rst_so_valid", k, int'(o_v[k]), 0);
                        chk("rst_so_last", k, int'(o_last[k]), 0);
                        chk("rst_busy", k, int'(o_busy[k]), 0);
                        chk("rst_in_ready", k, int'(o_rdy[k]), 1);
                        po[k]         = '0;
                        after_last[k] = 1'b0;
                        zc[k]         = 0;
                    end else begin
                        m_out(k, ecnt, ev, eb, el);
                        chk("so_valid", k, int'(o_v[k]), int'(ev));
                        chk("so", k, int'(o_so[k]), int'(ev & eb));
                        chk("so_last", k, int'(o_last[k]), int'(el));
                        chk("busy", k, int'(o_busy[k]), int'(m_busy(k, ecnt)));
                        chk("in_ready", k, int'(o_rdy[k]), int'(m_ready(k, ecnt)));
                        if (o_v[k]) begin
                            if (after_last[k]) begin
                                gapv[k]       = zc[k];
                                after_last[k] = 1'b0;
                            end
                            po[k] = {o_so[k], po[k][W-1:1]};
                            if (o_last[k]) begin
                                if (nrx[k] < NMAX) rxw[k][nrx[k]] = po[k];
                                nrx[k]        = nrx[k] + 1;
                                after_last[k] = 1'b1;
                                zc[k]         = 0;
                            end
                        end else begin
                            zc[k] = zc[k] + 1;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word 1011: bits 1,1,0,1; sipo reassembles 1011.
        b0[0] = nrx[0];
        send(0, 4'b1011);
        iv[0] = 1'b0;
        wait_cycles(10);
        chk("t1_count", 0, nrx[0] - b0[0], 1);
        chk("t1_word", 0, int'(rxw[0][b0[0]]), 4'hB);

        // Back-to-back A then 5 with no bubble.
        b0[0] = nrx[0];
        send(0, 4'hA);
        send(0, 4'h5);
        iv[0] = 1'b0;
        wait_cycles(14);
        chk("t2_count", 0, nrx[0] - b0[0], 2);
        chk("t2_word0", 0, int'(rxw[0][b0[0]]), 4'hA);
        chk("t2_word1", 0, int'(rxw[0][b0[0]+1]), 4'h5);
        chk("t2_gap", 0, gapv[0], 0);

        // Two-cycle gap between 3 and C.
        b0[1] = nrx[1];
        send(1, 4'h3);
        send(1, 4'hC);
        iv[1] = 1'b0;
        wait_cycles(16);
        chk("t3_count", 1, nrx[1] - b0[1], 2);
        chk("t3_word0", 1, int'(rxw[1][b0[1]]), 4'h3);
        chk("t3_word1", 1, int'(rxw[1][b0[1]+1]), 4'hC);
        chk("t3_gap", 1, gapv[1], 2);

        // Backpressure: 1,2,3 with valid held high, each exactly once in order.
        b0[1] = nrx[1];
        send(1, 4'h1);
        send(1, 4'h2);
        send(1, 4'h3);
        iv[1] = 1'b0;
        wait_cycles(24);
        chk("t4_count", 1, nrx[1] - b0[1], 3);
        chk("t4_word0", 1, int'(rxw[1][b0[1]]), 4'h1);
        chk("t4_word1", 1, int'(rxw[1][b0[1]+1]), 4'h2);
        chk("t4_word2", 1, int'(rxw[1][b0[1]+2]), 4'h3);

        // Reset two bits into F with 6 waiting in the holding buffer.
        b0[0] = nrx[0];
        send(0, 4'hF);
        send(0, 4'h6);
        iv[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_so", k, int'(o_so[k]), 0);
            chk("t5_so_valid", k, int'(o_v[k]), 0);
            chk("t5_so_last", k, int'(o_last[k]), 0);
            chk("t5_busy", k, int'(o_busy[k]), 0);
            chk("t5_in_ready", k, int'(o_rdy[k]), 1);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        wait_cycles(12);
        chk("t5_no_frames", 0, nrx[0] - b0[0], 0);

        // Randomized traffic on both instances.
        for (int k = 0; k < 2; k++) begin
            b0[k]   = nrx[k];
            a0[k]   = acc_cnt[k];
            m0[k]   = nf[k];
            seen[k] = acc_cnt[k];
        end
        repeat (600) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!iv[k] || acc_cnt[k] != seen[k]) begin
                    iv[k] = ($urandom_range(0, 3) != 0);
                    id[k] = W'($urandom);
                end
                seen[k] = acc_cnt[k];
            end
        end
        @(negedge clk);
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        wait_cycles(30);
        for (int k = 0; k < 2; k++) begin
            chk("rnd_count", k, nrx[k] - b0[k], acc_cnt[k] - a0[k]);
            for (int i = 0; i < acc_cnt[k] - a0[k] && i < 300; i++)
                chk("rnd_word", k, int'(rxw[k][b0[k]+i]), int'(fw[k][m0[k]+i]));
            chk("idle_busy", k, int'(o_busy[k]), 0);
            chk("idle_so_valid", k, int'(o_v[k]), 0);
            chk("idle_so", k, int'(o_so[k]), 0);
            chk("idle_in_ready", k, int'(o_rdy[k]), 1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
